seg7_scan_arb: RTL and testbench
================================

// Module: seg7_scan_arb
// PURPOSE
//   Time-multiplexed driver for the 8-digit 7-seg display (HEX/AN) on unisys.
//   Two requesters share the display; grant changes only at frame boundaries,
//   so a frame is never torn. Includes anti-ghost blanking and starvation guard.
// PARAMETERS
//   SCAN_DIV       100_000  clk cycles per digit slot (>= 2)
//   BLANK_CYC      16       cycles at start of each slot with AN all off (< SCAN_DIV)
//   STARVE_FRAMES  4        consecutive frames req[1] may be denied before forced grant (>= 1)
// PORTS
//   clk          in   1   system clock
//   rst          in   1   synchronous, active-high reset
//   req          in   2   display request; req[0] high priority
//   val0/val1    in   32  8 hex nibbles, nibble i -> digit i
//   en0/en1      in   8   per-digit enable (0 = digit blank)
//   dp0/dp1      in   8   per-digit decimal point (1 = lit)
//   gnt          out  2   one-hot current owner, 2'b00 = none
//   frame_start  out  1   1-cycle pulse when a new frame is latched
//   HEX          out  8   active-low segments: [0]=a .. [6]=g, [7]=dp
//   AN           out  8   active-low digit select, AN[i] = digit i
// BEHAVIOUR
//   Reset: HEX=8'hFF, AN=8'hFF, gnt=0, frame_start=0; slot cnt=0, digit=0,
//     shadow en=0, starve=0. Reset mid-frame aborts it; the display blanks next cycle.
//   Scan: cnt counts 0..SCAN_DIV-1; on wrap, digit increments mod 8.
//   Boundary = cycle with cnt==0 && digit==0; this includes the first cycle after rst drops.
//   Arbitration at boundary only (registered, visible the next cycle):
//     - req[1] && starve>=STARVE_FRAMES -> gnt=2'b10, starve=0
//     - else req[0] -> gnt=2'b01; starve+=1 if req[1], else starve=0 (saturating)
//     - else req[1] -> gnt=2'b10, starve=0
//     - else gnt=0, starve=0
//   Same boundary: shadow {val,en,dp} <= granted source, or en=0 if none.
//     frame_start=1 for the next cycle.
//   Mid-frame req/data changes are ignored. Dropping req keeps gnt until the next boundary.
//   Output (1-cycle registered latency from cnt/digit):
//     - cnt<BLANK_CYC or !en[digit] -> AN=8'hFF, HEX=8'hFF
//     - else AN=~(1<<digit); HEX[6:0]=~seg(val[4*digit+:4]); HEX[7]=~dp[digit]
//   seg(): standard hex glyphs, lit bits gfedcba: 0=3F 1=06 2=5B 3=4F 4=66 5=6D
//     6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
//   At most one AN bit is low in any cycle.
//   Elaboration error if BLANK_CYC>=SCAN_DIV or SCAN_DIV<2.
// STRUCTURE
//   seg7_pkg: localparam NDIG=8; typedef struct packed {logic[31:0] val;
//     logic[7:0] en, dp;} seg7_frame_t; function seg7_glyph(nibble)->7b active-high.
//   Sub-module seg7_frame_arb: boundary-time grant, starve counter, shadow frame.
//   Top holds the scan counters and the output register.
// TESTING (SCAN_DIV=4, BLANK_CYC=1, STARVE_FRAMES=2; frame = 32 cycles)
//   Reset, no req -> AN=FF, HEX=FF for all cycles; gnt=0; frame_start every 32 cycles.
//   req=01, val0=32'h76543210, en0=FF, dp0=0 -> slot i: 1 blank cycle, then 3 cycles of
//     AN=~(1<<i), HEX=~glyph(i); digit 0 HEX=8'hC0.
//   req 01->11 mid-frame -> gnt stays 01 until boundary. Hold 11: frames 01,01,10,01,01,10...
//   Frame 1 en0=FF; frame 2 change val0 mid-frame -> change appears only in the next frame.
//     Set en0=8'h0F, dp0=8'h01 -> digits 4-7 blank; digit 0 HEX[7]=0.
//   Assert rst mid-slot with digit=5 -> next cycle AN=FF, HEX=FF, gnt=0;
//     after release, the first boundary re-arbitrates immediately.
//   Assertion across all tests: $countones(~AN)<=1; frame_start only one cycle after a boundary.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types, digit count and hex glyph lookup for the 7-seg scan driver
package seg7_pkg;
    localparam int NDIG = 8;
    typedef struct packed {
        logic [31:0] val;
        logic [7:0]  en;
        logic [7:0]  dp;
    } seg7_frame_t;
    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
    function automatic logic [6:0] seg7_glyph(input logic [3:0] nibble);
        return GLYPH[nibble];
    endfunction
endpackage

// File: rtl/seg7_scan_arb_if.sv
// seg7_scan_arb_if: requester/display bundle
//   req, val0/val1, en0/en1, dp0/dp1 : requester -> driver
//   gnt, frame_start, HEX, AN        : driver -> requester/display pins
interface seg7_scan_arb_if;
    import seg7_pkg::*;
    logic [1:0]  req;
    logic [31:0] val0, val1;
    logic [7:0]  en0, en1, dp0, dp1;
    logic [1:0]  gnt;
    logic        frame_start;
    logic [7:0]  HEX, AN;
    modport master (
        output req, val0, val1, en0, en1, dp0, dp1,
        input  gnt, frame_start, HEX, AN
    );
    modport slave (
        input  req, val0, val1, en0, en1, dp0, dp1,
        output gnt, frame_start, HEX, AN
    );
endinterface

// File: rtl/seg7_frame_arb.sv
// seg7_frame_arb: frame-boundary arbitration, starvation guard and shadow frame
//   boundary_i    : cycle where a new frame begins
//   req_i         : requests, bit 0 has priority
//   f0_i/f1_i     : live frames of each requester
//   gnt_o         : one-hot owner of the current frame
//   frame_start_o : pulses the cycle after a boundary
//   frame_o       : frame in effect this cycle (new frame already visible on a boundary)
module seg7_frame_arb
    import seg7_pkg::*;
#(
    parameter int STARVE_FRAMES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        boundary_i,
    input  logic [1:0]  req_i,
    input  seg7_frame_t f0_i,
    input  seg7_frame_t f1_i,
    output logic [1:0]  gnt_o,
    output logic        frame_start_o,
    output seg7_frame_t frame_o
);
    localparam int SW = $clog2(STARVE_FRAMES + 1);
    localparam logic [SW-1:0] STARVE_L = SW'(STARVE_FRAMES);
    logic [1:0]    gnt_q, gnt_d, gnt_n;
    logic [SW-1:0] starve_q, starve_d, starve_n;
    seg7_frame_t   frame_q, frame_d;
    logic          fs_q;
    always_comb begin
        gnt_n    = (req_i[1] && starve_q >= STARVE_L) ? 2'b10 :
                   req_i[0] ? 2'b01 : req_i[1] ? 2'b10 : 2'b00;
        starve_n = (gnt_n == 2'b01 && req_i[1]) ?
                   ((starve_q == STARVE_L) ? starve_q : starve_q + 1'b1) : '0;
        gnt_d    = boundary_i ? gnt_n : gnt_q;
        starve_d = boundary_i ? starve_n : starve_q;
        frame_d  = !boundary_i ? frame_q : gnt_n[1] ? f1_i : gnt_n[0] ? f0_i : '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q    <= '0;
            starve_q <= '0;
            frame_q  <= '0;
            fs_q     <= 1'b0;
        end else begin
            gnt_q    <= gnt_d;
            starve_q <= starve_d;
            frame_q  <= frame_d;
            fs_q     <= boundary_i;
        end
    end
    assign gnt_o         = gnt_q;
    assign frame_start_o = fs_q;
    assign frame_o       = frame_d;
endmodule

// File: rtl/seg7_scan_arb.sv
// seg7_scan_arb: time-multiplexed 8-digit 7-seg driver shared by two requesters
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of seg7_scan_arb_if (requests, frames, gnt, frame_start, HEX, AN)
module seg7_scan_arb
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV      = 100_000,
    parameter int BLANK_CYC     = 16,
    parameter int STARVE_FRAMES = 4
) (
    input logic            clk,
    input logic            rst,
    seg7_scan_arb_if.slave bus
);
    if (SCAN_DIV < 2 || BLANK_CYC >= SCAN_DIV) begin : g_param_err
        $error("seg7_scan_arb: need SCAN_DIV >= 2 and BLANK_CYC < SCAN_DIV");
    end
    localparam int CW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(NDIG);
    localparam logic [CW-1:0] LAST_L  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_L = CW'(BLANK_CYC);
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] dig_q, dig_d;
    logic [7:0]    an_q, an_d, hex_q, hex_d;
    logic [3:0]    nib;
    logic          boundary, blank;
    seg7_frame_t   f0, f1, cur;
    assign f0 = {bus.val0, bus.en0, bus.dp0};
    assign f1 = {bus.val1, bus.en1, bus.dp1};
    seg7_frame_arb #(.STARVE_FRAMES(STARVE_FRAMES)) u_arb (
        .clk          (clk),
        .rst          (rst),
        .boundary_i   (boundary),
        .req_i        (bus.req),
        .f0_i         (f0),
        .f1_i         (f1),
        .gnt_o        (bus.gnt),
        .frame_start_o(bus.frame_start),
        .frame_o      (cur)
    );
    // Blanking the head of every slot hides ghosting while AN switches digits.
    always_comb begin
        cnt_d    = (cnt_q == LAST_L) ? '0 : cnt_q + 1'b1;
        dig_d    = (cnt_q == LAST_L) ? dig_q + 1'b1 : dig_q;
        boundary = (cnt_q == '0) && (dig_q == '0);
        nib      = cur.val[{dig_q, 2'b00} +: 4];
        blank    = (cnt_q < BLANK_L) || !cur.en[dig_q];
        an_d     = blank ? 8'hFF : ~(8'h01 << dig_q);
        hex_d    = blank ? 8'hFF : {~cur.dp[dig_q], ~seg7_glyph(nib)};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            dig_q <= '0;
            an_q  <= 8'hFF;
            hex_q <= 8'hFF;
        end else begin
            cnt_q <= cnt_d;
            dig_q <= dig_d;
            an_q  <= an_d;
            hex_q <= hex_d;
        end
    end
    assign bus.AN  = an_q;
    assign bus.HEX = hex_q;
endmodule

// File: tb/tb_seg7_scan_arb.sv
// tb_seg7_scan_arb: randomized directed bench against a cycle-indexed reference model
module tb_seg7_scan_arb;
    localparam int SD = 4, BC = 1, SF = 2, FR = SD * 8;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    seg7_scan_arb_if bus();
    seg7_scan_arb #(.SCAN_DIV(SD), .BLANK_CYC(BC), .STARVE_FRAMES(SF)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    int n_cmp = 0, n_bad = 0;
    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [1:0]  req_nx = 2'b00;
    logic        rst_nx = 1'b1;
    logic [31:0] v0_nx = '0, v1_nx = '0;
    logic [7:0]  e0_nx = '0, e1_nx = '0, p0_nx = '0, p1_nx = '0;
    bit          rnd = 1'b0;
    int          m_t = 0, m_starve = 0, m_gnt = 0;
    logic [31:0] m_val = '0;
    logic [7:0]  m_en = '0, m_dp = '0;
    logic [7:0]  e_an, e_hex;
    logic [1:0]  e_gnt;
    logic        e_fs;
    bit          have_exp = 1'b0;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h (model cycle %0d)", tag, obs, exp, m_t);
        end
    endtask
    task automatic model();
        int dig, off;
        bit lit;
        if (rst) begin
            m_t = 0; m_gnt = 0; m_starve = 0; m_en = '0;
            e_an = 8'hFF; e_hex = 8'hFF; e_gnt = 2'b00; e_fs = 1'b0;
            return;
        end
        e_fs = (m_t % FR == 0);
        if (e_fs) begin
            if (bus.req[1] && m_starve >= SF) begin m_gnt = 2; m_starve = 0; end
            else if (bus.req[0]) begin m_gnt = 1; m_starve = bus.req[1] ? m_starve + 1 : 0; end
            else if (bus.req[1]) begin m_gnt = 2; m_starve = 0; end
            else begin m_gnt = 0; m_starve = 0; end
            m_val = (m_gnt == 1) ? bus.val0 : bus.val1;
            m_dp  = (m_gnt == 1) ? bus.dp0 : bus.dp1;
            m_en  = (m_gnt == 1) ? bus.en0 : (m_gnt == 2) ? bus.en1 : 8'h00;
        end
        e_gnt = (m_gnt == 1) ? 2'b01 : (m_gnt == 2) ? 2'b10 : 2'b00;
        dig   = (m_t / SD) % 8;
        off   = m_t % SD;
        lit   = (off >= BC) && m_en[dig];
        e_an  = lit ? ~(8'd1 << dig) : 8'hFF;
        e_hex = lit ? {~m_dp[dig], ~glyph[(m_val >> (4 * dig)) & 32'hF]} : 8'hFF;
        m_t++;
    endtask
    task automatic cyc();
        @(negedge clk);
        if (have_exp) begin
            chk("AN", {24'b0, bus.AN}, {24'b0, e_an});
            chk("HEX", {24'b0, bus.HEX}, {24'b0, e_hex});
            chk("gnt", {30'b0, bus.gnt}, {30'b0, e_gnt});
            chk("frame_start", {31'b0, bus.frame_start}, {31'b0, e_fs});
            chk("an_single", {31'b0, $countones(~bus.AN) <= 1}, 32'd1);
        end
        if (rnd) begin
            if ($urandom_range(3) == 0) v0_nx = $urandom;
            if ($urandom_range(3) == 0) v1_nx = $urandom;
            if ($urandom_range(7) == 0) e0_nx = 8'($urandom);
            if ($urandom_range(7) == 0) e1_nx = 8'($urandom);
            if ($urandom_range(7) == 0) p0_nx = 8'($urandom);
            if ($urandom_range(7) == 0) p1_nx = 8'($urandom);
        end
        rst = rst_nx;
        bus.req = req_nx;
        bus.val0 = v0_nx; bus.val1 = v1_nx;
        bus.en0 = e0_nx; bus.en1 = e1_nx;
        bus.dp0 = p0_nx; bus.dp1 = p1_nx;
        model();
        have_exp = 1'b1;
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end
    initial begin
        bus.req = '0; bus.val0 = '0; bus.val1 = '0;
        bus.en0 = '0; bus.en1 = '0; bus.dp0 = '0; bus.dp1 = '0;
        repeat (3) cyc();
        rst_nx = 1'b0;
        repeat (2 * FR) cyc();
        req_nx = 2'b01; v0_nx = 32'h76543210; e0_nx = 8'hFF; p0_nx = 8'h00;
        v1_nx = 32'hFEDCBA98; e1_nx = 8'hFF; p1_nx = 8'hAA;
        repeat (FR + 10) cyc();
        req_nx = 2'b11;
        repeat (6 * FR + 4) cyc();
        req_nx = 2'b01;
        while (m_t % FR != 12) cyc();
        v0_nx = 32'h89ABCDEF; e0_nx = 8'h0F; p0_nx = 8'h01;
        repeat (2 * FR) cyc();
        rnd = 1'b1;
        repeat (12) begin
            req_nx = 2'($urandom_range(3));
            repeat ($urandom_range(8, 48)) cyc();
        end
        rnd = 1'b0;
        req_nx = 2'b01; e0_nx = 8'hFF;
        repeat (FR) cyc();
        while (m_t % FR != 22) cyc();
        rst_nx = 1'b1;
        cyc();
        rst_nx = 1'b0; req_nx = 2'b10; e1_nx = 8'hFF;
        repeat (2 * FR + 2) cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
